traffic_light_ctrl: RTL and testbench

- Moore FSM that sequences a two-road intersection: a main road, a side road, and a pedestrian crossing.
- All phase durations are counted in ticks of an external timebase enable, supplied by the board clock divider.
- Outputs drive the main/side RYG LEDs and the WALK LED. A debug state code is exported for the 7-segment display.

---
 rtl/traffic_light_ctrl_if.sv | 34 +++
 rtl/traffic_light_ctrl.sv | 157 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic light controller and its board.
// Carries the timebase, sensors, lamp drives and debug state code.
interface traffic_light_ctrl_if;
  logic       tick;
  logic       ped_req;
  logic       side_car;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_id;

  modport master (
    output tick,
    output ped_req,
    output side_car,
    input  main_light,
    input  side_light,
    input  walk,
    input  ped_pending,
    input  state_id
  );

  modport slave (
    input  tick,
    input  ped_req,
    input  side_car,
    output main_light,
    output side_light,
    output walk,
    output ped_pending,
    output state_id
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Moore FSM for a main/side road intersection with a pedestrian phase.
// Phase lengths are counted in ticks of an external timebase enable.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 5
) (
  input logic                 clk,
  input logic                 RESET,
  traffic_light_ctrl_if.slave bus
);

  localparam int MAX_GY =
    (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_AW =
    (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
  localparam int MAX_DUR =
    (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int TW = $clog2(MAX_DUR) + 1;

  localparam logic [TW-1:0] GREEN_M1  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_M1 = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_M1 = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] WALK_M1   = TW'(WALK_TICKS - 1);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALLRED1     = 3'd2,
    S_SIDE_GREEN  = 3'd3,
    S_SIDE_YELLOW = 3'd4,
    S_ALLRED2     = 3'd5,
    S_WALK        = 3'd6,
    S_UNUSED      = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_q, ped_d;
  logic [TW-1:0] dur_m1;
  logic          timeout;
  logic          enter_walk;

  // Register the phase, its tick counter and the pending pedestrian request.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= S_MAIN_GREEN;
      timer_q <= '0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
    end
  end

  // Select the last timer value of the current phase.
  always_comb begin
    dur_m1 = GREEN_M1;
    case (state_q)
      S_MAIN_GREEN:  dur_m1 = GREEN_M1;
      S_MAIN_YELLOW: dur_m1 = YELLOW_M1;
      S_ALLRED1:     dur_m1 = ALLRED_M1;
      S_SIDE_GREEN:  dur_m1 = GREEN_M1;
      S_SIDE_YELLOW: dur_m1 = YELLOW_M1;
      S_ALLRED2:     dur_m1 = ALLRED_M1;
      S_WALK:        dur_m1 = WALK_M1;
      default:       dur_m1 = GREEN_M1;
    endcase
  end

  assign timeout = bus.tick & (timer_q == dur_m1);

  // Phase sequencing; decisions are taken only when the phase times out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_GREEN: begin
        if (timeout && (bus.side_car || ped_q))
          state_d = S_MAIN_YELLOW;
      end
      S_MAIN_YELLOW: begin
        if (timeout)
          state_d = S_ALLRED1;
      end
      S_ALLRED1: begin
        if (timeout)
          state_d = ped_q ? S_WALK : S_SIDE_GREEN;
      end
      S_WALK: begin
        if (timeout)
          state_d = bus.side_car ? S_SIDE_GREEN : S_ALLRED2;
      end
      S_SIDE_GREEN: begin
        if (timeout)
          state_d = S_SIDE_YELLOW;
      end
      S_SIDE_YELLOW: begin
        if (timeout)
          state_d = S_ALLRED2;
      end
      S_ALLRED2: begin
        if (timeout)
          state_d = S_MAIN_GREEN;
      end
      default: state_d = S_MAIN_GREEN;
    endcase
  end

  // Tick counter: restarts on phase change, holds once the phase end
  // is reached so an idle main green waits at its last count.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (bus.tick && (timer_q != dur_m1))
      timer_d = timer_q + 1'b1;
  end

  assign enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

  // Pedestrian request latch; entering WALK serves and clears it.
  always_comb begin
    ped_d = ped_q;
    if (bus.ped_req && (state_q != S_WALK))
      ped_d = 1'b1;
    if (enter_walk)
      ped_d = 1'b0;
  end

  // Lamp drive decoded from the current phase only.
  always_comb begin
    bus.main_light = LAMP_R;
    bus.side_light = LAMP_R;
    bus.walk       = 1'b0;
    case (state_q)
      S_MAIN_GREEN:  bus.main_light = LAMP_G;
      S_MAIN_YELLOW: bus.main_light = LAMP_Y;
      S_SIDE_GREEN:  bus.side_light = LAMP_G;
      S_SIDE_YELLOW: bus.side_light = LAMP_Y;
      S_WALK:        bus.walk       = 1'b1;
      default: begin
        bus.main_light = LAMP_R;
        bus.side_light = LAMP_R;
      end
    endcase
  end

  assign bus.ped_pending = ped_q;
  assign bus.state_id    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed testbench for traffic_light_ctrl.
// Second instance uses unit durations with tick tied high.
module tb_traffic_light_ctrl;

  logic clk;
  logic RESET;
  logic rst2;
  int   checks;
  int   errors;

  traffic_light_ctrl_if bus ();
  traffic_light_ctrl_if bus2 ();

  traffic_light_ctrl dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  traffic_light_ctrl #(
    .GREEN_TICKS  (1),
    .YELLOW_TICKS (1),
    .ALLRED_TICKS (1),
    .WALK_TICKS   (1)
  ) dut2 (
    .clk   (clk),
    .RESET (rst2),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_main(int s);
    case (s)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(int s);
    case (s)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic do_tick(int n);
    repeat (n) begin
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ped();
    bus.ped_req = 1'b1;
    @(posedge clk);
    #1;
    bus.ped_req = 1'b0;
  endtask

  task automatic do_reset(logic car);
    bus.side_car = car;
    bus.tick     = 1'b0;
    bus.ped_req  = 1'b0;
    RESET        = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  task automatic chk_state(string nm, int s);
    checks++;
    if (bus.state_id !== 3'(s)) begin
      errors++;
      $display("FAIL %s: state_id got %0d want %0d",
               nm, bus.state_id, s);
    end
  endtask

  task automatic chk_pend(string nm, logic p);
    checks++;
    if (bus.ped_pending !== p) begin
      errors++;
      $display("FAIL %s: ped_pending got %b want %b",
               nm, bus.ped_pending, p);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.tick = 1'b0;
    bus.ped_req = 1'b0;
    bus.side_car = 1'b0;
    #1;
    checks++;
    if (bus.main_light !== 3'b001 || bus.side_light !== 3'b100
        || bus.walk !== 1'b0 || bus.state_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_out: m=%b s=%b w=%b id=%0d want 001 100 0 0",
               bus.main_light, bus.side_light, bus.walk, bus.state_id);
    end
    chk_pend("reset_pend", 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      do_tick(1);
      checks++;
      if (bus.main_light !== 3'b001 || bus.side_light !== 3'b100
          || bus.walk !== 1'b0 || bus.state_id !== 3'd0) begin
        errors++;
        $display("FAIL idle_hold t%0d: m=%b s=%b w=%b id=%0d want 001 100 0 0",
                 i + 1, bus.main_light, bus.side_light,
                 bus.walk, bus.state_id);
      end
    end
  endtask

  task automatic test_side_cycle();
    int st [6] = '{0, 1, 2, 3, 4, 5};
    int du [6] = '{8, 3, 1, 8, 3, 1};
    do_reset(1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 6; s++) begin
        for (int k = 0; k < du[s]; k++) begin
          checks++;
          if (bus.state_id !== 3'(st[s])
              || bus.main_light !== exp_main(st[s])
              || bus.side_light !== exp_side(st[s])
              || bus.walk !== 1'b0) begin
            errors++;
            $display("FAIL side_cycle r%0d s%0d k%0d: id=%0d m=%b s=%b w=%b want id=%0d",
                     r, s, k, bus.state_id, bus.main_light,
                     bus.side_light, bus.walk, st[s]);
          end
          do_tick(1);
        end
      end
    end
    chk_state("side_cycle_end", 0);
  endtask

  task automatic test_ped_basic();
    do_reset(1'b0);
    do_tick(2);
    pulse_ped();
    chk_pend("ped_latch", 1'b1);
    do_tick(6);
    chk_state("ped_my_t8", 1);
    do_tick(4);
    chk_state("ped_walk_t12", 6);
    checks++;
    if (bus.walk !== 1'b1 || bus.ped_pending !== 1'b0
        || bus.main_light !== 3'b100 || bus.side_light !== 3'b100) begin
      errors++;
      $display("FAIL ped_walk_out: w=%b p=%b m=%b s=%b want 1 0 100 100",
               bus.walk, bus.ped_pending, bus.main_light, bus.side_light);
    end
    do_tick(5);
    chk_state("ped_ar2_t17", 5);
    do_tick(1);
    chk_state("ped_mg_t18", 0);
    chk_pend("ped_done", 1'b0);
  endtask

  task automatic test_ped_hold();
    do_reset(1'b0);
    do_tick(2);
    pulse_ped();
    do_tick(9);
    chk_state("hold_ar1", 2);
    bus.tick = 1'b1;
    bus.ped_req = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.ped_req = 1'b0;
    chk_state("hold_walk", 6);
    chk_pend("hold_enter_clear", 1'b0);
    @(posedge clk);
    #1;
    pulse_ped();
    chk_pend("hold_walk_ignore", 1'b0);
    bus.side_car = 1'b1;
    do_tick(5);
    chk_state("hold_walk_sg", 3);
    pulse_ped();
    chk_pend("hold_sg_latch", 1'b1);
    do_tick(8);
    chk_state("hold_sy", 4);
    do_tick(3);
    chk_state("hold_ar2", 5);
    do_tick(1);
    chk_state("hold_mg", 0);
    chk_pend("hold_persist", 1'b1);
    bus.side_car = 1'b0;
    do_tick(8);
    chk_state("hold_my", 1);
    do_tick(3);
    chk_state("hold_ar1b", 2);
    do_tick(1);
    chk_state("hold_walk2", 6);
    chk_pend("hold_served", 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    do_tick(12);
    chk_state("ar_sg", 3);
    pulse_ped();
    chk_pend("ar_pend", 1'b1);
    do_tick(2);
    #3;
    RESET = 1'b1;
    #1;
    checks++;
    if (bus.main_light !== 3'b001 || bus.side_light !== 3'b100
        || bus.ped_pending !== 1'b0 || bus.state_id !== 3'd0
        || bus.walk !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: m=%b s=%b p=%b id=%0d w=%b want 001 100 0 0 0",
               bus.main_light, bus.side_light, bus.ped_pending,
               bus.state_id, bus.walk);
    end
    bus.tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.tick = 1'b0;
    #3;
    RESET = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      do_tick(1);
      chk_state("ar_full_green", 0);
    end
    do_tick(1);
    chk_state("ar_exit_t8", 1);
  endtask

  task automatic test_back_to_back();
    int ex [10] = '{1, 2, 6, 3, 4, 5, 0, 1, 2, 3};
    bus2.ped_req = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus2.ped_req = 1'b0;
      checks++;
      if (bus2.state_id !== 3'(ex[i])
          || bus2.main_light !== exp_main(ex[i])
          || bus2.side_light !== exp_side(ex[i])
          || bus2.walk !== (ex[i] == 6)) begin
        errors++;
        $display("FAIL b2b step%0d: id=%0d m=%b s=%b w=%b want id=%0d",
                 i, bus2.state_id, bus2.main_light,
                 bus2.side_light, bus2.walk, ex[i]);
      end
      checks++;
      if (bus2.main_light !== 3'b100 && bus2.side_light !== 3'b100) begin
        errors++;
        $display("FAIL b2b_conflict step%0d: m=%b s=%b",
                 i, bus2.main_light, bus2.side_light);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst2 = 1'b1;
    bus2.tick = 1'b1;
    bus2.side_car = 1'b1;
    bus2.ped_req = 1'b0;
    test_reset();
    test_side_cycle();
    test_ped_basic();
    test_ped_hold();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
